spram_arbiter: RTL and testbench

- Shares one SB_SPRAM256KA-style single-port RAM between two requesters.
- Port 0 is the panel scan read path; port 1 is the host or frame-writer read/write path.
- Arbitrates per cycle, steers address, data and mask to the RAM, and returns read data with a per-port valid strobe.
- Idle power management: drops the RAM into STANDBY after a configurable idle period and sequences the wake-up.

---
 rtl/spram_arbiter.sv | 153 +++++++++++++++
 tb/tb_spram_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arbiter.sv
// Two-port arbiter and power sequencer for one SB_SPRAM256KA-style single-port RAM.
// Define SPRAM_ARB_FIXED_PRIO_EN to give port 0 absolute priority instead of round-robin.
module spram_arbiter #(
    parameter int AW           = 14,
    parameter int DW           = 16,
    parameter int IDLE_TIMEOUT = 64,
    parameter int WAKE_CYCLES  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_valid,
    output logic          p0_ready,
    input  logic          p0_write,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic [3:0]    p0_wmask,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_valid,
    output logic          p1_ready,
    input  logic          p1_write,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic [3:0]    p1_wmask,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] spram_addr,
    output logic [DW-1:0] spram_wdata,
    output logic [3:0]    spram_maskwren,
    output logic          spram_wren,
    output logic          spram_cs,
    output logic          spram_standby,
    input  logic [DW-1:0] spram_rdata
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 2);
    localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST =
        IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] IDLE_MAX  = '1;
    localparam logic [WW-1:0] WAKE_LAST =
        WW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_STANDBY = 2'd1,
        ST_WAKE    = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [WW-1:0] wake_q, wake_d;
    logic          last_q, last_d;
    logic          stby_q, stby_d;
    logic          rv0_q, rv0_d;
    logic          rv1_q, rv1_d;
    logic          active;
    logic          gnt0, gnt1;
    logic          any_valid;

    assign active    = (state_q == ST_ACTIVE) && !rst;
    assign any_valid = p0_valid || p1_valid;

`ifdef SPRAM_ARB_FIXED_PRIO_EN
    assign gnt0 = active && p0_valid;
    assign gnt1 = active && p1_valid && !p0_valid;
`else
    // last_q == 1 means port 1 won last, so port 0 takes the next tie
    assign gnt0 = active && p0_valid && (!p1_valid || last_q);
    assign gnt1 = active && p1_valid && (!p0_valid || !last_q);
`endif

    assign p0_ready       = gnt0;
    assign p1_ready       = gnt1;
    assign spram_addr     = gnt1 ? p1_addr  : p0_addr;
    assign spram_wdata    = gnt1 ? p1_wdata : p0_wdata;
    assign spram_maskwren = gnt1 ? p1_wmask : p0_wmask;
    assign spram_cs       = gnt0 || gnt1;
    assign spram_wren     = (gnt0 && p0_write) || (gnt1 && p1_write);
    assign spram_standby  = stby_q;

    // Reset squashes a read response that is still in flight
    assign p0_rvalid = rv0_q && !rst;
    assign p1_rvalid = rv1_q && !rst;
    assign p0_rdata  = spram_rdata;
    assign p1_rdata  = spram_rdata;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        last_d  = last_q;
        rv0_d   = gnt0 && !p0_write;
        rv1_d   = gnt1 && !p1_write;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
        case (state_q)
            ST_ACTIVE: begin
                if (any_valid) begin
                    idle_d = '0;
                end else if (IDLE_TIMEOUT != 0 && idle_q == IDLE_LAST) begin
                    state_d = ST_STANDBY;
                    idle_d  = '0;
                end else if (idle_q != IDLE_MAX) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_STANDBY: begin
                wake_d = '0;
                if (any_valid) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (wake_q == WAKE_LAST) begin
                    state_d = ST_ACTIVE;
                    wake_d  = '0;
                    idle_d  = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
        stby_d = (state_d == ST_STANDBY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            idle_q  <= '0;
            wake_q  <= '0;
            last_q  <= 1'b1;
            stby_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            last_q  <= last_d;
            stby_q  <= stby_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter with a behavioural SPRAM model.
// A second instance with IDLE_TIMEOUT = 0 watches that standby never asserts.
module tb_spram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p0_write, p1_valid, p1_write;
    logic [13:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic [3:0]  p0_wmask, p1_wmask;
    logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [13:0] spram_addr;
    logic [15:0] spram_wdata, spram_rdata;
    logic [3:0]  spram_maskwren;
    logic        spram_wren, spram_cs, spram_standby;

    logic        z_p0_ready, z_p1_ready, z_p0_rvalid, z_p1_rvalid;
    logic [15:0] z_p0_rdata, z_p1_rdata, z_wdata;
    logic [13:0] z_addr;
    logic [3:0]  z_mask;
    logic        z_wren, z_cs, z_standby;
    logic        z_seen_standby;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] mem [0:16383];

    always #5 clk = ~clk;

    spram_arbiter #(.AW(14), .DW(16), .IDLE_TIMEOUT(4), .WAKE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_write(p0_write),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_write(p1_write),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .spram_addr(spram_addr), .spram_wdata(spram_wdata),
        .spram_maskwren(spram_maskwren), .spram_wren(spram_wren),
        .spram_cs(spram_cs), .spram_standby(spram_standby),
        .spram_rdata(spram_rdata)
    );

    spram_arbiter #(.AW(14), .DW(16), .IDLE_TIMEOUT(0), .WAKE_CYCLES(2)) u_dut_nopm (
        .clk(clk), .rst(rst),
        .p0_valid(1'b0), .p0_ready(z_p0_ready), .p0_write(1'b0),
        .p0_addr(14'h0), .p0_wdata(16'h0), .p0_wmask(4'h0),
        .p0_rvalid(z_p0_rvalid), .p0_rdata(z_p0_rdata),
        .p1_valid(1'b0), .p1_ready(z_p1_ready), .p1_write(1'b0),
        .p1_addr(14'h0), .p1_wdata(16'h0), .p1_wmask(4'h0),
        .p1_rvalid(z_p1_rvalid), .p1_rdata(z_p1_rdata),
        .spram_addr(z_addr), .spram_wdata(z_wdata),
        .spram_maskwren(z_mask), .spram_wren(z_wren),
        .spram_cs(z_cs), .spram_standby(z_standby),
        .spram_rdata(16'h0)
    );

    // SPRAM model: registered read, nibble-masked write
    always @(posedge clk) begin
        if (spram_cs) begin
            if (spram_wren) begin
                logic [15:0] t;
                t = mem[spram_addr];
                for (int i = 0; i < 4; i++)
                    if (spram_maskwren[i]) t[i*4 +: 4] = spram_wdata[i*4 +: 4];
                mem[spram_addr] <= t;
            end else begin
                spram_rdata <= mem[spram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (rst) z_seen_standby <= 1'b0;
        else if (z_standby === 1'b1) z_seen_standby <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expected read word for every rvalid the DUT presents
    always @(negedge clk) begin
        if (p0_rvalid === 1'b1) begin
            if (q0.size() == 0) chk("p0 unexpected rvalid", 32'd1, 32'd0);
            else chk("p0_rdata", {16'h0, p0_rdata}, {16'h0, q0.pop_front()});
        end
        if (p1_rvalid === 1'b1) begin
            if (q1.size() == 0) chk("p1 unexpected rvalid", 32'd1, 32'd0);
            else chk("p1_rdata", {16'h0, p1_rdata}, {16'h0, q1.pop_front()});
        end
    end

    task automatic drv0(input logic v, input logic w, input logic [13:0] a,
                        input logic [15:0] d, input logic [3:0] m);
        p0_valid = v; p0_write = w; p0_addr = a; p0_wdata = d; p0_wmask = m;
    endtask

    task automatic drv1(input logic v, input logic w, input logic [13:0] a,
                        input logic [15:0] d, input logic [3:0] m);
        p1_valid = v; p1_write = w; p1_addr = a; p1_wdata = d; p1_wmask = m;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp0;
        rst = 1'b1;
        drv0(1, 1, 14'h10, 16'h0BAD, 4'hF);
        drv1(0, 0, 14'h0, 16'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst cs", spram_cs, 0);
        chk("rst wren", spram_wren, 0);
        chk("rst p0_ready", p0_ready, 0);
        chk("rst standby", spram_standby, 0);
        chk("rst rvalid", {p0_rvalid, p1_rvalid}, 0);

        step(); rst = 1'b0;
        drv0(1, 1, 14'h10, 16'hBEEF, 4'hF);
        @(negedge clk);
        chk("wr p0_ready", p0_ready, 1);
        chk("wr wren", spram_wren, 1);
        chk("wr addr", spram_addr, 14'h10);
        chk("wr wdata", spram_wdata, 16'hBEEF);
        step(); drv0(1, 0, 14'h10, 16'h0, 4'h0);
        @(negedge clk);
        chk("rd p0_ready", p0_ready, 1);
        chk("rd cs/wren", {spram_cs, spram_wren}, 2'b10);
        q0.push_back(16'hBEEF);
        step(); drv0(1, 1, 14'h1, 16'h1234, 4'hF);
        @(negedge clk);
        chk("wr1 p0_ready", p0_ready, 1);
        step(); drv0(0, 0, 14'h0, 16'h0, 4'h0);
        drv1(1, 1, 14'h2, 16'hABCD, 4'hF);
        @(negedge clk);
        chk("wr2 p1_ready", p1_ready, 1);
        chk("wr2 addr", spram_addr, 14'h2);
        step(); drv1(1, 1, 14'h2, 16'h00FF, 4'h3);
        @(negedge clk);
        chk("mask wr", spram_maskwren, 4'h3);
        chk("mask wdata", spram_wdata, 16'h00FF);
        step(); drv1(1, 0, 14'h2, 16'h0, 4'h0);
        @(negedge clk);
        chk("rd2 p1_ready", p1_ready, 1);
        q1.push_back(16'hABFF);
        step(); drv1(0, 0, 14'h0, 16'h0, 4'h0);
        step(); rst = 1'b1;
        step(); rst = 1'b0;

        // Contention from the first cycle after reset
        drv0(1, 0, 14'h1, 16'h0, 4'h0);
        drv1(1, 0, 14'h2, 16'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
`ifdef SPRAM_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (k % 2 == 0);
`endif
            chk("rr p0_ready", p0_ready, exp0);
            chk("rr p1_ready", p1_ready, !exp0);
            chk("rr addr", spram_addr, exp0 ? 14'h1 : 14'h2);
            if (exp0) q0.push_back(16'h1234);
            else q1.push_back(16'hABFF);
            step();
        end
        drv0(0, 0, 14'h0, 16'h0, 4'h0);
        drv1(0, 0, 14'h0, 16'h0, 4'h0);

        // Standby entry 5 cycles after the last transfer
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("idle standby", spram_standby, (k == 5));
            if (k < 5) step();
        end
        step(); drv1(1, 0, 14'h2, 16'h0, 4'h0);
        @(negedge clk);
        chk("stby p1_ready", p1_ready, 0);
        chk("stby cs", spram_cs, 0);
        chk("stby standby", spram_standby, 1);
        step();
        @(negedge clk);
        chk("wake1 standby", spram_standby, 0);
        chk("wake1 p1_ready", p1_ready, 0);
        step();
        @(negedge clk);
        chk("wake2 p1_ready", p1_ready, 0);
        step();
        @(negedge clk);
        chk("wake done p1_ready", p1_ready, 1);
        q1.push_back(16'hABFF);
        step(); drv1(0, 0, 14'h0, 16'h0, 4'h0);

        // Request on the timeout cycle cancels standby entry
        repeat (3) @(posedge clk);
        #1 drv0(1, 0, 14'h1, 16'h0, 4'h0);
        @(negedge clk);
        chk("cancel p0_ready", p0_ready, 1);
        chk("cancel standby", spram_standby, 0);
        q0.push_back(16'h1234);
        step(); drv0(0, 0, 14'h0, 16'h0, 4'h0);
        @(negedge clk);
        chk("cancel next standby", spram_standby, 0);

        // Reset during WAKE
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("re-idle standby", spram_standby, 1);
        step(); drv1(1, 1, 14'h2, 16'h5555, 4'hF);
        @(negedge clk);
        chk("stby2 p1_ready", p1_ready, 0);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("rst wake cs/wren", {spram_cs, spram_wren}, 0);
        chk("rst wake p1_ready", p1_ready, 0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("post rst p1_ready", p1_ready, 1);
        chk("post rst wren", spram_wren, 1);
        chk("post rst standby", spram_standby, 0);

        // Reset while a read response is pending
        step(); drv1(1, 0, 14'h2, 16'h0, 4'h0);
        @(negedge clk);
        chk("pend rd p1_ready", p1_ready, 1);
        step(); rst = 1'b1;
        drv1(0, 0, 14'h0, 16'h0, 4'h0);
        drv0(1, 1, 14'h1, 16'hDEAD, 4'hF);
        @(negedge clk);
        chk("rst rd p1_rvalid", p1_rvalid, 0);
        chk("rst rd cs/wren", {spram_cs, spram_wren}, 0);
        chk("rst rd p0_ready", p0_ready, 0);
        step(); rst = 1'b0;
        drv0(1, 0, 14'h1, 16'h0, 4'h0);
        @(negedge clk);
        chk("after rst p0_ready", p0_ready, 1);
        chk("after rst standby", spram_standby, 0);
        chk("after rst rvalid", p1_rvalid, 0);
        q0.push_back(16'h1234);
        step(); drv0(1, 0, 14'h2, 16'h0, 4'h0);
        @(negedge clk);
        chk("rd 5555 p0_ready", p0_ready, 1);
        q0.push_back(16'h5555);
        step(); drv0(0, 0, 14'h0, 16'h0, 4'h0);

        repeat (1005) @(posedge clk);
        @(negedge clk);
        chk("no-pm standby never", z_seen_standby, 0);
        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
